// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller: the in-flight instruction
// record kept per stage and the "no forwarding" select value.
package pipe_hazard_pkg;

  // Widest register address the tracker can hold; narrower addresses are zero-extended.
  localparam int MAX_REG_ADDR_W = 8;
  localparam int FWD_REGFILE    = 0;

  typedef struct packed {
    logic                      valid;
    logic [MAX_REG_ADDR_W-1:0] rd;
    logic                      regwrite;
    logic                      is_load;
  } trk_entry_t;

endpackage

// File: rtl/src_fwd_match.sv
// Priority match of one RF source register against the tracked stages,
// producing its forwarding select and a load-in-EX hit for interlocking.
module src_fwd_match
  import pipe_hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int SEL_W      = 2,
  parameter int ZERO_REG   = 31
) (
  input  logic [MAX_REG_ADDR_W-1:0]   src,
  input  logic                        src_used,
  input  trk_entry_t [NUM_STAGES-1:0] entries,
  output logic [SEL_W-1:0]            sel,
  output logic                        load_hit
);

  logic [NUM_STAGES-1:0] hit;

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      hit[k] = src_used && (src != MAX_REG_ADDR_W'(ZERO_REG)) &&
               entries[k].valid && entries[k].regwrite && (entries[k].rd == src);
    end
  end

  // Walk from the oldest stage down so the youngest producer wins; a load
  // still in EX has no data yet and is left to the interlock instead.
  always_comb begin
    sel = SEL_W'(FWD_REGFILE);
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (hit[k] && !(k == 0 && entries[k].is_load)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

  assign load_hit = hit[0] && entries[0].is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a short in-order pipeline: tracks in-flight destinations,
// drives forwarding selects, load-use interlock, branch squash and memory freeze.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_STAGES = 3,
  parameter int DELAY_SLOT = 1,
  parameter int ZERO_REG   = 31
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              id_valid,
  input  logic [REG_ADDR_W-1:0]             id_rn,
  input  logic [REG_ADDR_W-1:0]             id_rm,
  input  logic                              id_rn_used,
  input  logic                              id_rm_used,
  input  logic [REG_ADDR_W-1:0]             id_rd,
  input  logic                              id_regwrite,
  input  logic                              id_is_load,
  input  logic                              id_br_taken,
  input  logic                              mem_busy,
  output logic                              stall_if,
  output logic                              bubble_ex,
  output logic                              flush_rf,
  output logic                              pipe_freeze,
  output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_a_sel,
  output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_b_sel,
  output logic [31:0]                       stall_cycles
);

  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  trk_entry_t [NUM_STAGES-1:0] tracker;
  trk_entry_t                  new_entry;
  logic [SEL_W-1:0]            sel_a, sel_b;
  logic                        load_hit_a, load_hit_b;
  logic                        load_use;

  src_fwd_match #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W), .ZERO_REG(ZERO_REG)) u_match_a (
    .src      (MAX_REG_ADDR_W'(id_rn)),
    .src_used (id_rn_used),
    .entries  (tracker),
    .sel      (sel_a),
    .load_hit (load_hit_a)
  );

  src_fwd_match #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W), .ZERO_REG(ZERO_REG)) u_match_b (
    .src      (MAX_REG_ADDR_W'(id_rm)),
    .src_used (id_rm_used),
    .entries  (tracker),
    .sel      (sel_b),
    .load_hit (load_hit_b)
  );

  assign load_use = id_valid && (load_hit_a || load_hit_b);

  // Reset gates everything; a memory wait outranks the interlock and branches.
  always_comb begin
    stall_if    = 1'b0;
    bubble_ex   = 1'b0;
    flush_rf    = 1'b0;
    pipe_freeze = 1'b0;
    fwd_a_sel   = SEL_W'(FWD_REGFILE);
    fwd_b_sel   = SEL_W'(FWD_REGFILE);
    if (!reset) begin
      if (id_valid) begin
        fwd_a_sel = sel_a;
        fwd_b_sel = sel_b;
      end
      if (mem_busy) begin
        pipe_freeze = 1'b1;
        stall_if    = 1'b1;
      end else begin
        stall_if  = load_use;
        bubble_ex = load_use;
        flush_rf  = (DELAY_SLOT == 0) && id_valid && id_br_taken && !load_use;
      end
    end
  end

  always_comb begin
    new_entry = '0;
    if (id_valid && !bubble_ex) begin
      new_entry.valid    = 1'b1;
      new_entry.rd       = MAX_REG_ADDR_W'(id_rd);
      new_entry.regwrite = id_regwrite;
      new_entry.is_load  = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tracker <= '0;
    end else if (!mem_busy) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) begin
        tracker[k] <= tracker[k-1];
      end
      tracker[0] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
    end else if (stall_if && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued with each
// stimulus step and popped for comparison just before the following clock edge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst, mb, v;
    logic [4:0] rn;
    logic       rnu;
    logic [4:0] rm;
    logic       rmu;
    logic [4:0] rd;
    logic       rw, ld, br;
  } stim_t;

  typedef struct packed {
    logic        stall, bubble, flush1, flush0, freeze;
    logic [1:0]  fa, fb;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, id_valid, id_rn_used, id_rm_used, id_regwrite, id_is_load;
  logic        id_br_taken, mem_busy;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        stall_if, bubble_ex, flush_rf, pipe_freeze;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cycles;
  logic        ds0_stall_if, ds0_bubble_ex, ds0_flush_rf, ds0_pipe_freeze;
  logic [1:0]  ds0_fwd_a_sel, ds0_fwd_b_sel;
  logic [31:0] ds0_stall_cycles;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   step_no   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DELAY_SLOT(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_br_taken(id_br_taken),
    .mem_busy(mem_busy), .stall_if(stall_if), .bubble_ex(bubble_ex),
    .flush_rf(flush_rf), .pipe_freeze(pipe_freeze), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.DELAY_SLOT(0)) dut_ds0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_br_taken(id_br_taken),
    .mem_busy(mem_busy), .stall_if(ds0_stall_if), .bubble_ex(ds0_bubble_ex),
    .flush_rf(ds0_flush_rf), .pipe_freeze(ds0_pipe_freeze), .fwd_a_sel(ds0_fwd_a_sel),
    .fwd_b_sel(ds0_fwd_b_sel), .stall_cycles(ds0_stall_cycles)
  );

  function automatic stim_t st(input logic rst, mb, v, input int rn, input logic rnu,
                               input int rm, input logic rmu, input int rd,
                               input logic rw, ld, br);
    stim_t s;
    s.rst = rst; s.mb = mb; s.v = v;
    s.rn = 5'(rn); s.rnu = rnu; s.rm = 5'(rm); s.rmu = rmu; s.rd = 5'(rd);
    s.rw = rw; s.ld = ld; s.br = br;
    return s;
  endfunction

  function automatic exp_t ex(input logic stall, bubble, flush1, flush0, freeze,
                              input int fa, fb, cnt);
    exp_t e;
    e.stall = stall; e.bubble = bubble; e.flush1 = flush1; e.flush0 = flush0;
    e.freeze = freeze; e.fa = 2'(fa); e.fb = 2'(fb); e.cnt = 32'(cnt);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, expv);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    reset = s.rst; mem_busy = s.mb; id_valid = s.v;
    id_rn = s.rn; id_rn_used = s.rnu; id_rm = s.rm; id_rm_used = s.rmu;
    id_rd = s.rd; id_regwrite = s.rw; id_is_load = s.ld; id_br_taken = s.br;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_asserts++;
      n_fail++;
      $display("[TB] FAIL scoreboard step %0d: observed empty queue required one entry", step_no);
    end else begin
      e = exp_q.pop_front();
      chk("stall_if",     32'(stall_if),     32'(e.stall));
      chk("bubble_ex",    32'(bubble_ex),    32'(e.bubble));
      chk("flush_rf_ds1", 32'(flush_rf),     32'(e.flush1));
      chk("flush_rf_ds0", 32'(ds0_flush_rf), 32'(e.flush0));
      chk("pipe_freeze",  32'(pipe_freeze),  32'(e.freeze));
      chk("fwd_a_sel",    32'(fwd_a_sel),    32'(e.fa));
      chk("fwd_b_sel",    32'(fwd_b_sel),    32'(e.fb));
      chk("stall_cycles", stall_cycles,      e.cnt);
    end
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic step(input stim_t s, input exp_t e);
    applyStimulus(s, e);
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; mem_busy = 1'b0; id_valid = 1'b0; id_rn = '0; id_rm = '0;
    id_rn_used = 1'b0; id_rm_used = 1'b0; id_rd = '0; id_regwrite = 1'b0;
    id_is_load = 1'b0; id_br_taken = 1'b0;
    @(posedge clk);
    #1;

    // reset overrides mem_busy, a hazard-looking RF and a taken branch
    step(st(1,1,1,  1,1,  2,1,  3,1,1,1), ex(0,0,0,0,0, 0,0,0));
    // ADDI X1 enters EX, then RF reads X1 as Rn
    step(st(0,0,1,  4,1,  5,0,  1,1,0,0), ex(0,0,0,0,0, 0,0,0));
    step(st(0,0,1,  1,1,  6,1,  7,1,0,0), ex(0,0,0,0,0, 1,0,0));
    // LDUR X2 enters EX, RF reads X2 as Rm: one stall cycle then forward from MEM
    step(st(0,0,1,  9,1,  0,0,  2,1,1,0), ex(0,0,0,0,0, 0,0,0));
    step(st(0,0,1,  8,1,  2,1, 10,1,0,0), ex(1,1,0,0,0, 0,0,0));
    step(st(0,0,1,  8,1,  2,1, 10,1,0,0), ex(0,0,0,0,0, 0,2,1));
    // X3 written twice, then X31 written; youngest wins, zero register never forwards
    step(st(0,0,1,  0,0,  0,0,  3,1,0,0), ex(0,0,0,0,0, 0,0,1));
    step(st(0,0,1,  0,0,  0,0,  3,1,0,0), ex(0,0,0,0,0, 0,0,1));
    step(st(0,0,1,  3,1,  0,0, 31,1,0,0), ex(0,0,0,0,0, 1,0,1));
    step(st(0,0,1, 31,1,  3,1,  0,0,0,1), ex(0,0,0,1,0, 0,2,1));
    // invalid RF slot masks everything
    step(st(0,0,0,  3,1,  3,1,  0,0,0,1), ex(0,0,0,0,0, 0,0,1));
    // LDUR X4 in EX held by a three-cycle memory wait, then the interlock resumes
    step(st(0,0,1,  0,0,  0,0,  4,1,1,0), ex(0,0,0,0,0, 0,0,1));
    step(st(0,1,1,  4,1,  0,0, 13,1,0,1), ex(1,0,0,0,1, 0,0,1));
    step(st(0,1,1,  4,1,  0,0, 13,1,0,1), ex(1,0,0,0,1, 0,0,2));
    step(st(0,1,1,  4,1,  0,0, 13,1,0,1), ex(1,0,0,0,1, 0,0,3));
    step(st(0,0,1,  4,1,  0,0, 13,1,0,1), ex(1,1,0,0,0, 0,0,4));
    step(st(0,0,1,  4,1,  0,0, 13,1,0,1), ex(0,0,0,1,0, 2,0,5));
    // reset lands on a load-use stall; the following cycle is hazard-free
    step(st(0,0,1,  0,0,  0,0,  5,1,1,0), ex(0,0,0,0,0, 0,0,5));
    step(st(1,0,1,  0,0,  5,1, 14,1,0,0), ex(0,0,0,0,0, 0,0,5));
    step(st(0,0,1,  0,0,  5,1, 14,1,0,0), ex(0,0,0,0,0, 0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 Parameter NUM_STAGES, default 3, tracked stages after RF (1=EX, 2=MEM, 3=WB).
REQ-003 Parameter DELAY_SLOT, default 1; 1 = instruction after a branch executes, 0 = it is squashed.
REQ-004 Parameter ZERO_REG, default 31, register that is never forwarded or interlocked.
REQ-005 clk  in  1  rising-edge clock; one clock only.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 id_valid  in  1  RF stage holds a real instruction.
REQ-008 id_rn, id_rm  in  REG_ADDR_W  RF source registers.
REQ-009 id_rn_used, id_rm_used  in  1  source actually read.
REQ-010 id_rd  in  REG_ADDR_W  RF destination.
REQ-011 id_regwrite, id_is_load  in  1  RF writes a register / is LDUR.
REQ-012 id_br_taken  in  1  branch resolved taken in RF.
REQ-013 mem_busy  in  1  data memory not ready; freezes whole pipe.
REQ-014 stall_if  out  1  hold PC and IF/RF register.
REQ-015 bubble_ex  out  1  load NOP into RF/EX register.
REQ-016 flush_rf  out  1  squash IF/RF contents next edge.
REQ-017 pipe_freeze  out  1  hold every pipeline register.
REQ-018 fwd_a_sel, fwd_b_sel  out  $clog2(NUM_STAGES+1)  0 = regfile, k = stage k result.
REQ-019 stall_cycles  out  32  saturating count of cycles with stall_if=1.

Function
REQ-020 Tracker SHALL hold NUM_STAGES entries {valid, rd, regwrite, is_load}; entry k = instruction in stage k.
REQ-021 On a non-frozen edge, entry[k+1] SHALL take entry[k]; entry[1] SHALL take RF instruction if id_valid and not bubble_ex, else invalid entry.
REQ-022 Source match SHALL require: source used, source != ZERO_REG, entry valid, entry regwrite, entry rd == source.
REQ-023 fwd_x_sel SHALL select the lowest-k matching entry; 0 if none; load in stage 1 never selected.
REQ-024 Load-use hazard = id_valid and either source matches entry[1] with is_load=1.
REQ-025 On load-use hazard SHALL assert stall_if=1, bubble_ex=1 for exactly one cycle; next cycle fwd_sel=2 for that source.
REQ-026 mem_busy=1 SHALL assert pipe_freeze=1, stall_if=1, bubble_ex=0, flush_rf=0; tracker holds; priority over all else.
REQ-027 DELAY_SLOT=0: id_br_taken with no stall SHALL assert flush_rf=1 for one cycle; DELAY_SLOT=1: flush_rf SHALL stay 0.
REQ-028 id_br_taken during load-use stall SHALL be ignored; branch re-evaluated next cycle.
REQ-029 All outputs except stall_cycles SHALL be combinational from inputs and tracker state, zero added latency.
REQ-030 stall_cycles SHALL increment once per stall_if cycle and hold at 0xFFFFFFFF.
REQ-031 id_valid=0 SHALL force stall_if, bubble_ex, flush_rf, fwd selects to 0 unless mem_busy.

Reset
REQ-032 reset=1 on an edge SHALL clear all entries to invalid and stall_cycles to 0, overriding mem_busy.
REQ-033 During reset, stall_if, bubble_ex, flush_rf, pipe_freeze and fwd selects SHALL be 0.
REQ-034 Reset mid-stall SHALL drop the pending stall; first post-reset cycle is hazard-free.

Structure
REQ-035 Package pipe_hazard_pkg SHALL hold the tracker-entry struct typedef and FWD_REGFILE=0 constant.
REQ-036 Sub-module src_fwd_match SHALL implement one source's priority match; instantiated twice.

Verification
REQ-037 ADDI X1 in EX, RF reads X1 as Rn -> fwd_a_sel=1, no stall.
REQ-038 LDUR X2 in EX, RF reads X2 as Rm -> stall_if=1, bubble_ex=1 one cycle, then fwd_b_sel=2, stall_cycles=1.
REQ-039 X3 written in EX and MEM, RF reads X3 -> fwd_a_sel=1; write to X31 in EX, RF reads X31 -> fwd_a_sel=0.
REQ-040 DELAY_SLOT=0, id_br_taken=1 -> flush_rf=1 one cycle; DELAY_SLOT=1 -> flush_rf=0.
REQ-041 mem_busy=1 for 3 cycles with LDUR in EX -> pipe_freeze=1 3 cycles, tracker unchanged, then load-use stall resumes.
REQ-042 reset asserted during load-use stall -> next cycle all outputs 0, stall_cycles=0.
